// File: rtl/cpu7_ifu_fetchq.sv
// Instruction fetch unit front end: issues one fetch at a time to the I-cache
// and buffers returned instructions in a circular queue feeding decode.
module cpu7_ifu_fetchq #(
  parameter int FETCH_W = 4,
  parameter int DEPTH   = 8,
  localparam int CW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1,
  localparam int QW = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [31:0]           pc_init,
  output logic                  inst_req,
  output logic [31:0]           inst_addr,
  input  logic                  inst_addr_ok,
  input  logic                  inst_valid,
  input  logic [CW-1:0]         inst_count,
  input  logic [32*FETCH_W-1:0] inst_rdata,
  input  logic                  inst_ex,
  input  logic [5:0]            inst_exccode,
  output logic                  inst_cancel,
  input  logic                  br_cancel,
  input  logic [31:0]           br_target,
  output logic                  fdp_dec_valid,
  input  logic                  fdp_dec_ready,
  output logic [31:0]           fdp_dec_inst,
  output logic [31:0]           fdp_dec_pc,
  output logic                  fdp_dec_ex,
  output logic [5:0]            fdp_dec_exccode,
  output logic [QW-1:0]         fq_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_STALL,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  exc;
  } entry_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_fpc, w_fpc_nxt;
  entry_t        r_q [DEPTH];
  logic [PW-1:0] r_rptr, r_wptr;
  logic [QW-1:0] r_count, w_count_nxt;
  logic [QW-1:0] w_enq_n, w_resp_n;
  logic          w_enq_ex;
  logic          w_deq;
  logic          w_flush;
  entry_t        w_head;

  assign w_flush  = br_cancel & (r_state != S_IDLE);
  assign w_resp_n = QW'(inst_count & CW'(FETCH_W - 1)) + QW'(1);
  assign w_deq    = fdp_dec_valid & fdp_dec_ready;
  assign w_head   = r_q[r_rptr];

  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_enq_n     = '0;
    w_enq_ex    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_fpc_nxt   = pc_init;
        w_state_nxt = S_REQ;
      end
      S_REQ: if (inst_addr_ok) w_state_nxt = S_WAIT;
      S_WAIT: if (inst_valid) begin
        if (inst_ex) begin
          w_enq_n     = QW'(1);
          w_enq_ex    = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          w_enq_n     = w_resp_n;
          w_fpc_nxt   = r_fpc + (32'(w_resp_n) << 2);
          w_state_nxt = S_STALL;
        end
      end
      default: ;
    endcase
    w_count_nxt = r_count + w_enq_n - QW'(w_deq);
    // A completed fetch routes through STALL and leaves the same cycle if the
    // post-update occupancy already leaves room for a full fetch.
    if ((w_state_nxt == S_STALL) && ((DEPTH - int'(w_count_nxt)) >= FETCH_W))
      w_state_nxt = S_REQ;
    if (w_flush) begin
      w_state_nxt = S_REQ;
      w_fpc_nxt   = br_target;
      w_enq_n     = '0;
      w_enq_ex    = 1'b0;
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_fpc   <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      r_count <= w_count_nxt;
      if (w_flush) begin
        r_rptr <= '0;
        r_wptr <= '0;
      end else begin
        r_rptr <= r_rptr + PW'(w_deq);
        r_wptr <= r_wptr + PW'(w_enq_n);
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      if (i < 32'(w_enq_n)) begin
        if (w_enq_ex)
          r_q[r_wptr + PW'(i)] <= {r_fpc, 32'h0, 1'b1, inst_exccode};
        else
          r_q[r_wptr + PW'(i)] <= {r_fpc + 32'(4 * i), inst_rdata[32*i +: 32], 1'b0, 6'h0};
      end
    end
  end

  assign inst_req        = (r_state == S_REQ);
  assign inst_addr       = r_fpc;
  assign inst_cancel     = br_cancel & ((r_state == S_WAIT) | ((r_state == S_REQ) & inst_addr_ok));
  assign fdp_dec_valid   = (r_count != '0) & ~br_cancel;
  assign fdp_dec_inst    = w_head.inst;
  assign fdp_dec_pc      = w_head.pc;
  assign fdp_dec_ex      = w_head.ex;
  assign fdp_dec_exccode = w_head.exc;
  assign fq_count        = r_count;

endmodule

// File: doc/cpu7_ifu_fetchq.md
CPU7_IFU_FETCHQ -- requirements
Module: cpu7_ifu_fetchq

Interface (parameters)
REQ-001 The block SHALL have parameter FETCH_W, default 4: maximum instructions returned per fetch; legal values 1, 2, 4.
REQ-002 The block SHALL have parameter DEPTH, default 8: fetch-queue entries; a power of 2 and >= FETCH_W.
REQ-003 Derived widths SHALL be CW = max(1, log2(FETCH_W)) and QW = log2(DEPTH)+1.

Interface (ports)
REQ-004 clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 pc_init  in  32  boot PC, sampled in the first cycle after reset release.
REQ-007 inst_req  out  1  fetch request valid; inst_addr  out  32  fetch address; inst_addr_ok  in  1  request accepted.
REQ-008 inst_valid  in  1  response valid; inst_count  in  CW  number of valid instructions minus 1; inst_rdata  in  32*FETCH_W  instructions, slot 0 = lowest 32 bits.
REQ-009 inst_ex  in  1  fetch exception; inst_exccode  in  6  exception code.
REQ-010 inst_cancel  out  1  cancels an outstanding request.
REQ-011 br_cancel  in  1  redirect from execute; br_target  in  32  redirect PC.
REQ-012 fdp_dec_valid  out  1; fdp_dec_ready  in  1; fdp_dec_inst  out  32; fdp_dec_pc  out  32; fdp_dec_ex  out  1; fdp_dec_exccode  out  6.
REQ-013 fq_count  out  QW  current queue occupancy.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, WAIT, STALL and HALT; at most one request SHALL be outstanding.
REQ-015 IDLE SHALL last exactly one cycle after reset release: fpc <= pc_init, then go to REQ.
REQ-016 In REQ, inst_req=1 and inst_addr=fpc; on inst_addr_ok the FSM SHALL go to WAIT.
REQ-017 REQ SHALL be entered only when (DEPTH - fq_count) >= FETCH_W; otherwise the FSM SHALL wait in STALL with inst_req=0.
REQ-018 In WAIT, on inst_valid with inst_ex=0, the block SHALL:
  - enqueue inst_count+1 entries {fpc+4*i, slot i, ex=0} in slot order;
  - set fpc <= fpc + 4*(inst_count+1), modulo 2^32;
  - go to REQ or STALL per REQ-017, evaluated on post-update occupancy.
REQ-019 In WAIT, on inst_valid with inst_ex=1, the block SHALL enqueue one entry {fpc, 32'h0, ex=1, inst_exccode} and go to HALT; HALT SHALL leave only on br_cancel.
REQ-020 fdp_dec_valid SHALL be (queue non-empty) & ~br_cancel; head fields SHALL drive fdp_dec_*; the head SHALL be dequeued when fdp_dec_valid & fdp_dec_ready.
REQ-021 Enqueue and dequeue in the same cycle SHALL both take effect; fq_count SHALL update by (enqueued - dequeued).
REQ-022 On br_cancel in any state except IDLE, the block SHALL:
  - flush the queue (fq_count <= 0 next cycle);
  - set fpc <= br_target;
  - go to REQ;
  - drop any same-cycle inst_valid response with no enqueue.
REQ-023 inst_cancel SHALL equal br_cancel & (state==WAIT | (state==REQ & inst_addr_ok)); the cache delivers no response for a cancelled request.
REQ-024 br_cancel SHALL take priority over inst_valid, inst_ex, dequeue and stall decisions in the same cycle.
REQ-025 Queue pointers SHALL wrap modulo DEPTH; the queue SHALL never overflow or underflow.
REQ-026 inst_valid outside WAIT SHALL be ignored.

Reset
REQ-027 While resetn=0: state=IDLE, fpc=0, queue pointers=0, fq_count=0, inst_req=0, inst_cancel=0, fdp_dec_valid=0.
REQ-028 Assertion of resetn=0 mid-operation SHALL discard all queue contents and any outstanding request immediately.
REQ-029 fdp_dec_inst/pc/exccode SHALL be don't-care while fdp_dec_valid=0.

Verification
REQ-030 Boot: pc_init=32'h1c000000, addr_ok same cycle, response inst_count=3 -> 4 entries with PCs 1c000000..1c00000c in order; next inst_addr=1c000010.
REQ-031 Backpressure: DEPTH=8, fdp_dec_ready=0, full 4-instruction fetches -> after 2 fetches fq_count=8 and inst_req stays 0; one dequeue -> still stalled; 4 dequeues -> REQ re-entered.
REQ-032 Redirect in WAIT: br_cancel=1, br_target=32'h1c000100, fq_count=5 -> inst_cancel=1 that cycle, fdp_dec_valid=0, next cycle fq_count=0, inst_addr=1c000100.
REQ-033 Collision: br_cancel and inst_valid in the same cycle -> no entries enqueued; fetch resumes at br_target.
REQ-034 Exception: inst_ex=1, exccode=6'h08 -> single entry ex=1, exccode=08; inst_req=0 until br_cancel.
REQ-035 Partial response: fpc=32'h1c000008, inst_count=1 -> 2 entries; next inst_addr=1c000010; simultaneous dequeue gives fq_count +1.
